// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the DM_CS/DM_R/DM_W interface.
// Accepts one word access at a time, inserts WAIT_CYCLES wait states,
// then answers with a one-cycle DM_RDY pulse and an error qualifier.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DM_CS,
    input  logic        DM_R,
    input  logic        DM_W,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        DM_RDY,
    output logic        DM_ERR,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Counter preload; unused when there are no wait states.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;

    logic [31:0] req_addr_reg, req_wdata_reg;
    logic        req_r_reg, req_w_reg;

    // Request currently being served. With zero wait states the response is
    // committed on the accept edge itself, before the latch has loaded, so
    // in IDLE the live inputs stand in for the latched copy.
    logic [31:0]           cur_addr, cur_wdata;
    logic                  cur_r, cur_w;
    logic                  cur_err;
    logic [DEPTH_LOG2-1:0] cur_idx;

    logic accept;
    logic enter_resp;

    logic [31:0] mem [DEPTH];

    // Select live inputs in IDLE, latched request otherwise; classify it.
    always_comb begin
        cur_addr  = req_addr_reg;
        cur_wdata = req_wdata_reg;
        cur_r     = req_r_reg;
        cur_w     = req_w_reg;
        if (state_reg == ST_IDLE) begin
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_r     = DM_R;
            cur_w     = DM_W;
        end
        cur_idx = cur_addr[DEPTH_LOG2+1:2];
        cur_err = (cur_r == cur_w)
                || (cur_addr[1:0] != 2'b00)
                || ((cur_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    end

    // Next-state logic and wait-state counter.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (DM_CS) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        enter_resp = (state_next == ST_RESP) && (state_reg != ST_RESP);
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            DM_RDY       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            DM_RDY       <= (state_next == ST_RESP);
            busy         <= (state_next != ST_IDLE);
        end
    end

    // Capture the request on acceptance; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_reg  <= 32'd0;
            req_wdata_reg <= 32'd0;
            req_r_reg     <= 1'b0;
            req_w_reg     <= 1'b0;
        end else if (accept) begin
            req_addr_reg  <= addr;
            req_wdata_reg <= wdata;
            req_r_reg     <= DM_R;
            req_w_reg     <= DM_W;
        end
    end

    // Memory write port: commits good writes on the edge entering RESP.
    // No reset on the array; reset only blocks an in-flight write.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_w && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    // Registered read port and error qualifier, updated entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata  <= 32'd0;
            DM_ERR <= 1'b0;
        end else if (enter_resp) begin
            if (cur_err) begin
                rdata  <= 32'd0;
                DM_ERR <= 1'b1;
            end else begin
                DM_ERR <= 1'b0;
                if (cur_r) begin
                    rdata <= mem[cur_idx];
                end
            end
        end else begin
            DM_ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: unit 0 runs with two wait states,
// unit 1 with none. Stimulus pushes expected responses; a monitor pops them.
module tb_dmem_responder;

    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  cs  = 2'b00;
    logic [1:0]  rr  = 2'b00;
    logic [1:0]  ww  = 2'b00;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic [1:0]  rdy;
    logic [1:0]  er;
    logic [1:0]  bsy;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          acc_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .DM_CS(cs[0]), .DM_R(rr[0]), .DM_W(ww[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .DM_RDY(rdy[0]),
        .DM_ERR(er[0]), .busy(bsy[0])
    );

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .DM_CS(cs[1]), .DM_R(rr[1]), .DM_W(ww[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .DM_RDY(rdy[1]),
        .DM_ERR(er[1]), .busy(bsy[1])
    );

    task automatic check(input string name, input int u, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            $display("FAIL %s u%0d: got %h want %h (cycle %0d)", name, u, act, req, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: on every response pop the oldest expectation and compare.
    exp_t mon_e;
    bit   mon_have;
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rdy[u] === 1'b1) begin
                mon_have = 1'b0;
                if (u == 0 && q0.size() > 0) begin
                    mon_e = q0.pop_front();
                    mon_have = 1'b1;
                end else if (u == 1 && q1.size() > 0) begin
                    mon_e = q1.pop_front();
                    mon_have = 1'b1;
                end
                if (!mon_have) begin
                    n_checks++;
                    $display("FAIL spurious_rdy u%0d: got DM_RDY=1 want none pending (cycle %0d)", u, cyc);
                end else begin
                    check("resp_err", u, 64'(er[u]), 64'(mon_e.err));
                    check("resp_rdata", u, 64'(rd[u]), 64'(mon_e.data));
                    check("resp_latency", u, 64'(cyc - mon_e.acc_cyc),
                          64'((u == 0 ? W0 : W1) + 1));
                    $display("resp u%0d: err=%0b rdata=%h at cycle %0d", u, er[u], rd[u], cyc);
                end
            end else if (er[u] !== 1'b0) begin
                check("err_without_rdy", u, 64'(er[u]), 64'd0);
            end
        end
    end

    // One access: wait for idle, present it, hold until DM_RDY, then release.
    // scramble changes the request fields while the access is in flight.
    task automatic access(input int u, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic exp_err,
                          input logic [31:0] exp_rd, input bit scramble);
        exp_t e;
        int t;
        t = 0;
        while (bsy[u] !== 1'b0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        cs[u] = 1'b1; rr[u] = r; ww[u] = w; ad[u] = a; wd[u] = d;
        e.err = exp_err;
        if (exp_err)        e.data = 32'd0;
        else if (r && !w)   e.data = exp_rd;
        else                e.data = model_rd[u];
        model_rd[u] = e.data;
        e.acc_cyc = cyc;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        $display("req  u%0d: r=%0b w=%0b addr=%h wdata=%h", u, r, w, a, d);
        @(posedge clk); #1;
        if (scramble) begin
            ad[u] = 32'h0000_0020; rr[u] = ~r; ww[u] = ~w; wd[u] = 32'hFFFF_FFFF;
        end
        t = 0;
        while (rdy[u] !== 1'b1 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (rdy[u] !== 1'b1) begin
            n_checks++;
            $display("FAIL rdy_timeout u%0d: got no DM_RDY want DM_RDY within 40 cycles", u);
        end
        cs[u] = 1'b0; rr[u] = 1'b0; ww[u] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ad[0] = 32'd0; ad[1] = 32'd0; wd[0] = 32'd0; wd[1] = 32'd0;
        model_rd[0] = 32'd0; model_rd[1] = 32'd0;

        // Reset for two cycles, then idle for ten with all outputs low.
        repeat (2) @(posedge clk);
        #1 rst = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++)
                check("idle_outputs", u, 64'({rd[u], rdy[u], er[u], bsy[u]}), 64'd0);
        end

        // Unit 0: write then read back with two wait states.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

        // Error cases; the word at 0x10 must survive each one.
        access(0, 1'b0, 1'b1, 32'h11, 32'h0BAD_0BAD, 1'b1, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 1'b1, 32'h1000, 32'h0BAD_0BAD, 1'b1, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        access(0, 1'b1, 1'b1, 32'h10, 32'h0BAD_0BAD, 1'b1, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

        // Reset in the WAIT cycle aborts a write to 0x20.
        access(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);
        @(posedge clk); #1;
        cs[0] = 1'b1; rr[0] = 1'b0; ww[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h12345678;
        $display("req  u0: write addr=00000020 wdata=12345678 (to be aborted)");
        @(posedge clk); #1;
        check("accepted_busy", 0, 64'(bsy[0]), 64'd1);
        rst[0] = 1'b1; cs[0] = 1'b0; ww[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_outputs", 0, 64'({rd[0], rdy[0], er[0], bsy[0]}), 64'd0);
        model_rd[0] = 32'd0;
        rst[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);

        // Request fields change during WAIT; only the latched read counts.
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);

        // Unit 1: zero wait states, range boundaries.
        access(1, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        access(1, 1'b0, 1'b1, 32'hFFC, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1111_1111, 1'b0);
        access(1, 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h2222_2222, 1'b0);
        access(1, 1'b0, 1'b0, 32'hFFC, 32'h0, 1'b1, 32'h0, 1'b0);
        access(1, 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h2222_2222, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check("queue0_drained", 0, 64'(q0.size()), 64'd0);
        check("queue1_drained", 1, 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
